// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state encodings and legal parameter limits for the phase generator.
// Latency: n/a (constants and a constant-evaluable legality check only).
// Backpressure: n/a.
package cpu_pkg;

  // FSM state encodings (kept as plain constants for legacy-compatible decode)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Legal parameter limits
  localparam int NPHASE_MIN    = 4;
  localparam int NPHASE_MAX    = 16;
  localparam int FETCH_LEN_MIN = 1;

  // True when the (NPHASE, FETCH_LEN, ALU_PHASE) triple is a legal configuration.
  // Fetch must leave at least two non-fetch phases, and the ALU pulse must land
  // after the fetch window but inside the instruction cycle.
  function automatic bit params_legal(input int nphase, input int fetch_len,
                                      input int alu_phase);
    return (nphase >= NPHASE_MIN) && (nphase <= NPHASE_MAX) &&
           (fetch_len >= FETCH_LEN_MIN) && (fetch_len <= nphase - 2) &&
           (alu_phase >= fetch_len) && (alu_phase <= nphase - 1);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// phase_counter: binary phase register 0..NPHASE-1 with wrap flag and next-phase view.
// Latency: phase updates one sys_clk edge after clr/adv; wrap and phase_nxt are combinational.
// Backpressure: adv=0 freezes the phase; clr forces phase 0 and overrides adv.
// Ports: sys_clk, rst_n (async active-low) | clr, adv in | phase, phase_nxt, wrap out.
module phase_counter #(
  parameter int NPHASE = 8,
  parameter int PW     = $clog2(NPHASE)
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [PW-1:0] phase,
  output logic [PW-1:0] phase_nxt,
  output logic          wrap
);

  assign wrap = (phase == PW'(NPHASE - 1));

  // Next phase is exported so the parent can register decoded outputs in step
  // with the phase register rather than one cycle behind it.
  always_comb begin
    phase_nxt = phase;
    if (clr) begin
      phase_nxt = '0;
    end else if (adv) begin
      phase_nxt = wrap ? '0 : phase + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else begin
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/phase_gen.sv
// phase_gen: instruction-cycle phase sequencer (IDLE/RUN/HOLD) with fetch/alu/cycle decode.
// Latency: every output registered and aligned with phase; first RUN phase one edge after en.
// Backpressure: en=0/hold=1 only take effect at the cycle wrap; a started cycle always completes.
// Ports: sys_clk, rst_n (async active-low), clk (sys_clk pass-through), en, hold,
//        phase[PW], fetch, alu_ena, cycle_start, busy, instr_cnt[16].
// Option PHASE_GEN_STEP_EN adds step_mode/step: with step_mode=1, RUN advances only when step=1.
module phase_gen
  import cpu_pkg::*;
#(
  parameter int NPHASE    = 8,
  parameter int FETCH_LEN = 4,
  parameter int ALU_PHASE = 5,
  localparam int PW       = $clog2(NPHASE)
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  output logic          clk,
  input  logic          en,
  input  logic          hold,
`ifdef PHASE_GEN_STEP_EN
  input  logic          step_mode,
  input  logic          step,
`endif
  output logic [PW-1:0] phase,
  output logic          fetch,
  output logic          alu_ena,
  output logic          cycle_start,
  output logic          busy,
  output logic [15:0]   instr_cnt
);

  if (!params_legal(NPHASE, FETCH_LEN, ALU_PHASE)) begin : g_param_err
    $error("phase_gen: illegal NPHASE/FETCH_LEN/ALU_PHASE combination");
  end

  assign clk = sys_clk;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          adv;
  logic          run_adv;
  logic          wrap;
  logic [PW-1:0] phase_nxt;

`ifdef PHASE_GEN_STEP_EN
  assign adv = !step_mode || step;
`else
  assign adv = 1'b1;
`endif

  assign run_adv = (state == ST_RUN) && adv;

  // Phase only moves while running; any other state parks it at 0.
  phase_counter #(
    .NPHASE (NPHASE),
    .PW     (PW)
  ) u_phase_counter (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .clr       (state != ST_RUN),
    .adv       (run_adv),
    .phase     (phase),
    .phase_nxt (phase_nxt),
    .wrap      (wrap)
  );

  // State changes out of RUN happen only at the wrap edge, so en/hold never
  // truncate a cycle. Dropping en beats hold at the wrap.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (run_adv && wrap) begin
          if (!en)       state_nxt = ST_IDLE;
          else if (hold) state_nxt = ST_HOLD;
          else           state_nxt = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (!en)       state_nxt = ST_IDLE;
        else if (!hold) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from next-state/next-phase so they land on the same edge
  // as the phase register. alu_ena requires an actual advance into ALU_PHASE,
  // which keeps it a single pulse when stepping stalls on that phase.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fetch       <= 1'b0;
      alu_ena     <= 1'b0;
      cycle_start <= 1'b0;
      busy        <= 1'b0;
      instr_cnt   <= 16'd0;
    end else begin
      state       <= state_nxt;
      fetch       <= (state_nxt == ST_RUN) && (phase_nxt < PW'(FETCH_LEN));
      alu_ena     <= (state_nxt == ST_RUN) && run_adv && (phase_nxt == PW'(ALU_PHASE));
      cycle_start <= (state_nxt == ST_RUN) && (phase_nxt == '0);
      busy        <= (state_nxt != ST_IDLE);
      if (run_adv && wrap) begin
        instr_cnt <= instr_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_phase_gen.sv
// tb_phase_gen: directed + randomized checks of phase_gen against a behavioural model.
// Latency: outputs checked 1 time unit after each rising sys_clk edge.
// Backpressure: n/a.
module tb_phase_gen;

  localparam int NP = 8;
  localparam int FL = 4;
  localparam int AP = 5;

  logic        sys_clk;
  logic        rst_n;
  logic        clk;
  logic        en;
  logic        hold;
  logic [2:0]  phase;
  logic        fetch;
  logic        alu_ena;
  logic        cycle_start;
  logic        busy;
  logic [15:0] instr_cnt;
`ifdef PHASE_GEN_STEP_EN
  logic        step_mode;
  logic        step;
`endif

  phase_gen #(
    .NPHASE    (NP),
    .FETCH_LEN (FL),
    .ALU_PHASE (AP)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .clk         (clk),
    .en          (en),
    .hold        (hold),
`ifdef PHASE_GEN_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .phase       (phase),
    .fetch       (fetch),
    .alu_ena     (alu_ena),
    .cycle_start (cycle_start),
    .busy        (busy),
    .instr_cnt   (instr_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: which mode the sequencer is in, where it is in the
  // instruction cycle, how many cycles have completed, and whether this
  // edge moved the cycle onto the ALU phase.
  typedef enum {M_IDLE, M_RUN, M_HOLD} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_ph    = 0;
  int      m_cnt   = 0;
  bit      m_alu   = 1'b0;
  int      m_alu_total = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_ph    = 0;
    m_cnt   = 0;
    m_alu   = 1'b0;
  endtask

  task automatic model_step();
    bit stepok;
    stepok = 1'b1;
`ifdef PHASE_GEN_STEP_EN
    stepok = !step_mode || step;
`endif
    m_alu = 1'b0;
    case (m_state)
      M_IDLE: if (en) begin m_state = M_RUN; m_ph = 0; end
      M_RUN: begin
        if (stepok) begin
          if (m_ph == NP - 1) begin
            m_cnt = (m_cnt + 1) % 65536;
            m_ph  = 0;
            if (!en)       m_state = M_IDLE;
            else if (hold) m_state = M_HOLD;
          end else begin
            m_ph = m_ph + 1;
            if (m_ph == AP) m_alu = 1'b1;
          end
        end
      end
      M_HOLD: begin
        m_ph = 0;
        if (!en)        m_state = M_IDLE;
        else if (!hold) m_state = M_RUN;
      end
      default: m_state = M_IDLE;
    endcase
    if (m_alu) m_alu_total++;
  endtask

  task automatic check_all(input string tag);
    bit running;
    running = (m_state == M_RUN);
    chk({tag, ".phase"},       16'(phase),       16'(m_ph));
    chk({tag, ".fetch"},       16'(fetch),       16'(running && (m_ph < FL)));
    chk({tag, ".alu_ena"},     16'(alu_ena),     16'(m_alu));
    chk({tag, ".cycle_start"}, 16'(cycle_start), 16'(running && (m_ph == 0)));
    chk({tag, ".busy"},        16'(busy),        16'(m_state != M_IDLE));
    chk({tag, ".instr_cnt"},   instr_cnt,        16'(m_cnt));
  endtask

  task automatic tick(input string tag);
    @(posedge sys_clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Advance until the model is in RUN at the target phase (bounded).
  task automatic run_until(input int target, input string tag);
    int n;
    n = 0;
    while (!(m_state == M_RUN && m_ph == target) && n < 40) begin
      tick(tag);
      n++;
    end
    chk({tag, ".reach"}, 16'(phase), 16'(target));
  endtask

  // Async reset pulse placed between clock edges; checks the immediate effect.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int pulses;
    rst_n = 1'b0;
    en    = 1'b0;
    hold  = 1'b0;
`ifdef PHASE_GEN_STEP_EN
    step_mode = 1'b0;
    step      = 1'b0;
`endif
    #1;
    check_all("reset");
    @(posedge sys_clk);
    #1;
    check_all("reset_edge");
    chk("clk_pass", 16'(clk), 16'(sys_clk));

    // Release with en=1: first RUN phase 0 one edge later, then 0..7 repeating.
    en = 1'b1;
    rst_n = 1'b1;
    tick("first_run");
    chk("first_fetch", 16'(fetch), 16'd1);
    for (int i = 0; i < 2 * NP + 3; i++) tick("seq");

    // en dropped at phase 2 of the first cycle after reset.
    pulse_reset("rst_a");
    run_until(2, "en_drop");
    en = 1'b0;
    n = 0;
    while (m_state != M_IDLE && n < 20) begin tick("en_drop"); n++; end
    chk("en_drop.busy", 16'(busy), 16'd0);
    chk("en_drop.cnt",  instr_cnt, 16'd1);

    // hold at phase 7 -> HOLD while hold is high, then phase 0 with fetch.
    en = 1'b1;
    run_until(NP - 1, "hold");
    hold = 1'b1;
    for (int i = 0; i < 4; i++) tick("holding");
    chk("hold.busy", 16'(busy), 16'd1);
    hold = 1'b0;
    tick("unhold");
    chk("unhold.fetch", 16'(fetch), 16'd1);
    chk("unhold.phase", 16'(phase), 16'd0);

    // en=0 and hold=1 at the wrap: IDLE wins.
    run_until(NP - 1, "both");
    en = 1'b0;
    hold = 1'b1;
    tick("both");
    chk("both.busy", 16'(busy), 16'd0);
    hold = 1'b0;
    en = 1'b1;

    // Reset mid-cycle at phase 4 aborts without counting.
    run_until(4, "midrst");
    pulse_reset("midrst");
    chk("midrst.cnt", instr_cnt, 16'd0);

    // Preload the counter near its limit and let one cycle wrap it.
    run_until(3, "preload");
    force dut.instr_cnt = 16'hFFFF;
    #1;
    release dut.instr_cnt;
    m_cnt = 16'hFFFF;
    chk("preload.val", instr_cnt, 16'hFFFF);
    run_until(NP - 1, "preload");
    tick("preload_wrap");
    chk("preload.wrap", instr_cnt, 16'd0);

    // Randomized run: en mostly high, hold occasionally, rare async resets.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      hold = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) pulse_reset("rnd_rst");
      tick("rnd");
    end

`ifdef PHASE_GEN_STEP_EN
    // Step mode: one phase per step pulse, a single alu_ena per instruction cycle.
    pulse_reset("step_rst");
    en = 1'b1;
    hold = 1'b0;
    step_mode = 1'b1;
    m_alu_total = 0;
    pulses = 0;
    for (int k = 0; k < 3 * NP * 2 + 3; k++) begin
      step = ((k % 3) == 2);
      tick("step");
      if (alu_ena) pulses++;
    end
    chk("step.alu_pulses", 16'(pulses), 16'(m_alu_total));
    step_mode = 1'b0;
    step = 1'b0;
`else
    pulses = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_gen.md
PHASE_GEN -- requirements
Module: phase_gen

Interface
REQ-001 SHALL have parameter NPHASE, default 8, number of phases per instruction cycle (legal 4..16).
REQ-002 SHALL have parameter FETCH_LEN, default 4, number of leading phases with fetch high (legal 1..NPHASE-2).
REQ-003 SHALL have parameter ALU_PHASE, default 5, zero-based phase index of the alu_ena pulse (legal FETCH_LEN..NPHASE-1).
REQ-004 SHALL derive localparam PW = $clog2(NPHASE) for the phase width.
REQ-005 SHALL have port sys_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port clk, output, 1, a direct combinational pass-through of sys_clk.
REQ-008 SHALL have port en, input, 1, run request.
REQ-009 SHALL have port hold, input, 1, freeze request, honoured only at a cycle boundary.
REQ-010 SHALL have port phase, output, PW, current phase index, binary.
REQ-011 SHALL have ports fetch, alu_ena, cycle_start and busy, each an output of width 1.
REQ-012 SHALL have port instr_cnt, output, 16, count of completed instruction cycles.

Function
REQ-013 SHALL implement FSM IDLE, RUN, HOLD; all outputs registered and aligned with the phase register.
REQ-014 IDLE: phase=0 and fetch/alu_ena/cycle_start/busy=0; en=1 -> RUN with phase=0 on the next edge.
REQ-015 RUN: phase increments by 1 per cycle and wraps NPHASE-1 -> 0.
REQ-016 At the wrap with en=0 -> IDLE; with en=1 and hold=1 -> HOLD; otherwise remain in RUN at phase 0.
REQ-017 en=0 or hold=1 during a cycle (phase != NPHASE-1) SHALL NOT truncate it; the cycle completes.
REQ-018 en=0 and hold=1 both at the wrap -> IDLE; IDLE has priority.
REQ-019 HOLD: phase=0 and fetch/alu_ena/cycle_start=0, busy=1; hold=0 -> RUN at phase 0; en=0 -> IDLE.
REQ-020 fetch=1 exactly when state is RUN and phase < FETCH_LEN.
REQ-021 alu_ena SHALL be a one-cycle pulse on the cycle in which phase enters ALU_PHASE in RUN.
REQ-022 cycle_start=1 when state is RUN and phase=0; busy=1 when state != IDLE.
REQ-023 instr_cnt SHALL increment on each RUN wrap from NPHASE-1, wrapping modulo 2^16.
REQ-024 Illegal parameter combinations SHALL cause an elaboration-time error.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, phase=0, instr_cnt=0, and fetch/alu_ena/cycle_start/busy=0.
REQ-026 Reset asserted mid-cycle SHALL abort the cycle without incrementing instr_cnt.
REQ-027 After rst_n deassertion with en=1, the first RUN phase 0 (fetch=1) SHALL appear one edge later.

Configuration
REQ-028 Macro PHASE_GEN_STEP_EN defined: SHALL add inputs step_mode and step (1 bit each).
REQ-029 With step_mode=1, RUN advances one phase only on cycles with step=1, otherwise holding phase and fetch while alu_ena stays a single pulse per cycle.
REQ-030 Macro undefined: SHALL omit step_mode and step, and phase SHALL advance every RUN cycle.

Structure
REQ-031 State encodings and the legal parameter limits SHALL live in shared package cpu_pkg.
REQ-032 The phase counter with its wrap flag SHALL be sub-module phase_counter; the FSM and output decode stay in phase_gen.

Verification (NPHASE=8, FETCH_LEN=4, ALU_PHASE=5)
REQ-033 Reset release with en=1 -> phase sequence 0..7 repeating, fetch high at phases 0-3, alu_ena pulsed at phase 5, cycle_start at phase 0.
REQ-034 en dropped at phase 2 -> cycle completes through phase 7, then IDLE with busy=0 and instr_cnt=1.
REQ-035 hold=1 at phase 7 -> HOLD for the duration of hold; hold=0 -> phase 0 with fetch=1 on the next edge.
REQ-036 en=0 and hold=1 both at phase 7 -> IDLE, not HOLD.
REQ-037 rst_n low at phase 4 -> all outputs 0 immediately and instr_cnt=0.
REQ-038 Preload instr_cnt to 16'hFFFF and run one cycle -> instr_cnt wraps to 0; with PHASE_GEN_STEP_EN, step_mode=1 and step every third cycle -> one phase per step with a single alu_ena pulse.
